// File: rtl/bpsk_symbol_shaper_src.sv
// bpsk_symbol_shaper_src
// Front end of the BPSK pulse-shaping FIR. Takes serial bits over a valid/ready
// handshake, maps each to +AMP / -AMP, zero-stuffs up to OSR samples per symbol,
// and paces samples with a one-cycle strobe every RATE_DIV clocks. When data runs
// out it emits FLUSH_LEN zero samples so the filter tail drains, then goes idle.
//
// Ports:
//   clk        clock; every register updates on the falling edge (filter's sampling edge)
//   reset      synchronous, active-high
//   bit_in     data bit (1 -> +AMP, 0 -> -AMP)
//   bit_valid  bit_in is valid
//   bit_ready  one-entry holding register can accept a bit
//   dout       signed sample to the filter's din; holds between strobes
//   flagout    one-cycle strobe marking a new dout sample (filter's flagin)
//   busy       block is running or flushing
module bpsk_symbol_shaper_src #(
  parameter int unsigned OSR       = 8,
  parameter int unsigned RATE_DIV  = 4,
  parameter int unsigned AMP       = 256,
  parameter int unsigned FLUSH_LEN = 43
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        bit_ready,
  output logic [31:0] dout,
  output logic        flagout,
  output logic        busy
);

  localparam int unsigned PhW  = $clog2(OSR);
  localparam int unsigned DivW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam int unsigned FlW  = $clog2(FLUSH_LEN + 1);

  localparam logic [PhW-1:0]  PhLast  = PhW'(OSR - 1);
  localparam logic [DivW-1:0] DivLast = DivW'(RATE_DIV - 1);
  localparam logic [FlW-1:0]  FlLast  = FlW'(FLUSH_LEN);
  localparam logic [31:0]     PosAmp  = 32'(AMP);
  localparam logic [31:0]     NegAmp  = ~PosAmp + 32'd1;

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e          state_q, state_d;
  logic            hold_valid_q, hold_valid_d;
  logic            hold_bit_q, hold_bit_d;
  logic [31:0]     dout_q, dout_d;
  logic            flag_q, flag_d;
  logic [PhW-1:0]  phase_q, phase_d;
  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [FlW-1:0]  flush_cnt_q, flush_cnt_d;

  logic        accept;
  logic        consume;
  logic        emit_tick;
  logic [31:0] sym;

  assign bit_ready = ~hold_valid_q & ~reset;
  assign accept    = bit_valid & bit_ready;
  assign emit_tick = (div_cnt_q == DivLast);
  assign sym       = hold_bit_q ? PosAmp : NegAmp;

  always_comb begin
    state_d     = state_q;
    hold_valid_d = hold_valid_q;
    hold_bit_d  = hold_bit_q;
    dout_d      = dout_q;
    flag_d      = 1'b0;
    phase_d     = phase_q;
    div_cnt_d   = div_cnt_q;
    flush_cnt_d = flush_cnt_q;
    consume     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (hold_valid_q) begin
          state_d   = StRun;
          dout_d    = sym;
          flag_d    = 1'b1;
          consume   = 1'b1;
          phase_d   = PhW'(1);
          div_cnt_d = '0;
        end
      end
      StRun: begin
        div_cnt_d = emit_tick ? '0 : div_cnt_q + 1'b1;
        if (emit_tick) begin
          flag_d = 1'b1;
          if (phase_q != '0) begin
            dout_d  = '0;
            phase_d = (phase_q == PhLast) ? '0 : phase_q + 1'b1;
          end else if (hold_valid_q) begin
            dout_d  = sym;
            consume = 1'b1;
            phase_d = PhW'(1);
          end else begin
            // This zero is already flush sample 1.
            dout_d = '0;
            if (FLUSH_LEN == 1) begin
              state_d   = StIdle;
              phase_d   = '0;
              div_cnt_d = '0;
            end else begin
              state_d     = StFlush;
              flush_cnt_d = FlW'(1);
            end
          end
        end
      end
      StFlush: begin
        div_cnt_d = emit_tick ? '0 : div_cnt_q + 1'b1;
        if (emit_tick) begin
          flag_d      = 1'b1;
          dout_d      = '0;
          flush_cnt_d = flush_cnt_q + 1'b1;
          if (FlW'(flush_cnt_q + 1'b1) == FlLast) begin
            state_d     = StIdle;
            phase_d     = '0;
            div_cnt_d   = '0;
            flush_cnt_d = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Accept needs an empty hold and consume a full one, so they never coincide.
    if (accept) begin
      hold_valid_d = 1'b1;
      hold_bit_d   = bit_in;
    end else if (consume) begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      hold_valid_q <= 1'b0;
      hold_bit_q   <= 1'b0;
      dout_q       <= '0;
      flag_q       <= 1'b0;
      phase_q      <= '0;
      div_cnt_q    <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      hold_bit_q   <= hold_bit_d;
      dout_q       <= dout_d;
      flag_q       <= flag_d;
      phase_q      <= phase_d;
      div_cnt_q    <= div_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign dout    = dout_q;
  assign flagout = flag_q;
  assign busy    = (state_q != StIdle);

endmodule
